// File: rtl/lcd_cmd_driver_if.sv
// LSU-side io_lcd register and HD44780 pin bundle for lcd_cmd_driver.
// master = LSU/board side, slave = the driver.
interface lcd_cmd_driver_if;
  logic [31:0] io_lcd;
  logic [7:0]  lcd_data_o;
  logic        lcd_rs_o;
  logic        lcd_rw_o;
  logic        lcd_en_o;
  logic        lcd_on_o;
  logic        lcd_busy_o;
  logic        lcd_done_o;
  logic        lcd_ovf_o;

  modport master (
    output io_lcd,
    input  lcd_data_o, lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_on_o,
           lcd_busy_o, lcd_done_o, lcd_ovf_o
  );

  modport slave (
    input  io_lcd,
    output lcd_data_o, lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_on_o,
           lcd_busy_o, lcd_done_o, lcd_ovf_o
  );
endinterface

// File: rtl/lcd_cmd_driver.sv
// Turns toggle-flagged io_lcd writes into HD44780 write cycles with a 1-deep buffer.
// Define LCD_INIT_EN to auto-issue the 0x38/0x0C/0x01/0x06 init sequence after reset.
module lcd_cmd_driver #(
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 12,
  parameter int HOLD_CYC  = 2,
  parameter int EXEC_CYC  = 2000,
  parameter int LONG_CYC  = 82000
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  lcd_cmd_driver_if.slave bus
);

  localparam int M0   = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int M1   = (M0 > HOLD_CYC) ? M0 : HOLD_CYC;
  localparam int M2   = (M1 > EXEC_CYC) ? M1 : EXEC_CYC;
  localparam int MAXC = (M2 > LONG_CYC) ? M2 : LONG_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

`ifdef LCD_INIT_EN
  localparam logic [2:0] INIT_START = 3'd0;
`else
  localparam logic [2:0] INIT_START = 3'd4;
`endif

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, EXEC} state_e;
  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } cmd_t;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          tog_q, on_q, en_q, done_q, ovf_q;
  cmd_t          act_q, buf_q;
  logic          buf_vld_q;
  logic [2:0]    init_idx_q;
  logic          init_cur_q;

  cmd_t new_cmd, init_cmd, nxt_cmd_d;
  logic det, exec_end, slot_free, init_pend;
  logic take_init, pop, take_det, start, is_long;

  always_comb begin
    new_cmd.rs   = bus.io_lcd[9];
    new_cmd.data = bus.io_lcd[7:0];
    init_cmd.rs  = 1'b0;
    case (init_idx_q[1:0])
      2'd0:    init_cmd.data = 8'h38;
      2'd1:    init_cmd.data = 8'h0C;
      2'd2:    init_cmd.data = 8'h01;
      default: init_cmd.data = 8'h06;
    endcase
    det       = bus.io_lcd[16] ^ tog_q;
    exec_end  = (state_q == EXEC) && (cnt_q == '0);
    // slot_free: the active registers can accept a new command on this edge
    slot_free = (state_q == IDLE) || exec_end;
    init_pend = !init_idx_q[2];
    take_init = slot_free && init_pend;
    pop       = slot_free && !init_pend && buf_vld_q;
    take_det  = slot_free && !init_pend && !buf_vld_q && det;
    start     = take_init || pop || take_det;
    nxt_cmd_d = take_init ? init_cmd : (pop ? buf_q : new_cmd);
    is_long   = !act_q.rs && (act_q.data inside {8'h01, 8'h02, 8'h03});
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tog_q      <= 1'b0;
      on_q       <= 1'b0;
      en_q       <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      act_q      <= '0;
      buf_q      <= '0;
      buf_vld_q  <= 1'b0;
      init_idx_q <= INIT_START;
      init_cur_q <= 1'b0;
    end else begin
      tog_q  <= bus.io_lcd[16];
      on_q   <= bus.io_lcd[31];
      done_q <= exec_end && !init_cur_q;
      if (start) begin
        state_q    <= SETUP;
        cnt_q      <= CW'(SETUP_CYC - 1);
        act_q      <= nxt_cmd_d;
        init_cur_q <= take_init;
        if (take_init) init_idx_q <= init_idx_q + 3'd1;
      end else begin
        case (state_q)
          IDLE: ;
          SETUP:
            if (cnt_q == '0) begin
              state_q <= PULSE;
              en_q    <= 1'b1;
              cnt_q   <= CW'(PULSE_CYC - 1);
            end else cnt_q <= cnt_q - CW'(1);
          PULSE:
            if (cnt_q == '0) begin
              state_q <= HOLD;
              en_q    <= 1'b0;
              cnt_q   <= CW'(HOLD_CYC - 1);
            end else cnt_q <= cnt_q - CW'(1);
          HOLD:
            if (cnt_q == '0) begin
              state_q <= EXEC;
              cnt_q   <= is_long ? CW'(LONG_CYC - 1) : CW'(EXEC_CYC - 1);
            end else cnt_q <= cnt_q - CW'(1);
          EXEC:
            if (cnt_q == '0) state_q <= IDLE;
            else             cnt_q   <= cnt_q - CW'(1);
          default: state_q <= IDLE;
        endcase
      end
      // A detect during a pop refills the slot being freed, so it is not an overflow.
      if (det && !take_det) begin
        if (!buf_vld_q || pop) begin
          buf_q     <= new_cmd;
          buf_vld_q <= 1'b1;
        end else begin
          ovf_q <= 1'b1;
        end
      end else if (pop) begin
        buf_vld_q <= 1'b0;
      end
    end
  end

  logic unused_io;
  assign unused_io = ^{bus.io_lcd[30:17], bus.io_lcd[15:10], bus.io_lcd[8]};

  assign bus.lcd_data_o = act_q.data;
  assign bus.lcd_rs_o   = act_q.rs;
  assign bus.lcd_rw_o   = 1'b0;
  assign bus.lcd_en_o   = en_q;
  assign bus.lcd_on_o   = on_q;
  assign bus.lcd_busy_o = (state_q != IDLE);
  assign bus.lcd_done_o = done_q;
  assign bus.lcd_ovf_o  = ovf_q;

endmodule

// File: tb/tb_lcd_cmd_driver.sv
// Scoreboard bench for lcd_cmd_driver: stimulus pushes expected commands/busy runs,
// a negedge monitor pops and compares as the pins move.
module tb_lcd_cmd_driver;
  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;

  lcd_cmd_driver_if bus();

  lcd_cmd_driver #(
    .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1), .EXEC_CYC(4), .LONG_CYC(10)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  logic [8:0] cq[$];
  int         bq[$];
  int         exp_done = 0;
  logic       snap_ovf = 1'b0;
  int         snap_id = 0;

  int   errors = 0, checks = 0;
  int   snap_seen = 0, done_cnt = 0, busy_run = 0, en_len = 0;
  logic prev_en = 1'b0, prev_busy = 1'b0, prev_done = 1'b0, first_en = 1'b1, on_exp = 1'b0;
  logic [8:0] e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      #1;
      chk("rst_en",   32'(bus.lcd_en_o),   0);
      chk("rst_busy", 32'(bus.lcd_busy_o), 0);
      chk("rst_data", 32'(bus.lcd_data_o), 0);
      chk("rst_rs",   32'(bus.lcd_rs_o),   0);
      chk("rst_ovf",  32'(bus.lcd_ovf_o),  0);
      chk("rst_done", 32'(bus.lcd_done_o), 0);
      chk("rst_on",   32'(bus.lcd_on_o),   0);
      busy_run = 0; en_len = 0; first_en = 1'b1;
      prev_en = 1'b0; prev_busy = 1'b0; prev_done = 1'b0; on_exp = 1'b0;
    end else begin
      chk("on", 32'(bus.lcd_on_o), 32'(on_exp));
      on_exp = bus.io_lcd[31];
      if (bus.lcd_busy_o) busy_run++;
      if (bus.lcd_en_o && !prev_en) begin
        chk("en_expected", 32'(cq.size() != 0), 1);
        if (cq.size() != 0) begin
          e = cq.pop_front();
          chk("cmd_rs_data", 32'({bus.lcd_rs_o, bus.lcd_data_o}), 32'(e));
        end
        chk("rw", 32'(bus.lcd_rw_o), 0);
        if (first_en) begin
          chk("en_offset", busy_run, 2);
          first_en = 1'b0;
        end
      end
      if (bus.lcd_en_o) en_len++;
      else if (prev_en) begin
        chk("en_len", en_len, 2);
        en_len = 0;
      end
      if (!bus.lcd_busy_o && prev_busy) begin
        chk("busy_expected", 32'(bq.size() != 0), 1);
        if (bq.size() != 0) chk("busy_len", busy_run, bq.pop_front());
        busy_run = 0; first_en = 1'b1;
      end
      if (bus.lcd_done_o) begin
        chk("done_width", 32'(prev_done), 0);
        done_cnt++;
      end
      if (snap_id != snap_seen) begin
        chk("snap_ovf",  32'(bus.lcd_ovf_o),  32'(snap_ovf));
        chk("snap_done", done_cnt, exp_done);
        chk("snap_busy", 32'(bus.lcd_busy_o), 0);
        chk("snap_cq",   cq.size(), 0);
        chk("snap_bq",   bq.size(), 0);
        snap_seen = snap_id;
      end
      prev_en = bus.lcd_en_o; prev_busy = bus.lcd_busy_o; prev_done = bus.lcd_done_o;
    end
  end

  task automatic wr(input logic [31:0] v);
    @(posedge clk); #1 bus.io_lcd = v;
  endtask

  task automatic snap(input logic ovf, input int wait_cyc);
    repeat (wait_cyc) @(posedge clk);
    snap_ovf = ovf;
    snap_id++;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    rst_ni = 1'b1;
    bus.io_lcd = '0;
    #2 rst_ni = 1'b0;
`ifdef LCD_INIT_EN
    cq.push_back(9'h038); cq.push_back(9'h00C); cq.push_back(9'h001); cq.push_back(9'h006);
    bq.push_back(38);
`endif
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;
`ifdef LCD_INIT_EN
    snap(1'b0, 50);
`endif
    // single data write
    cq.push_back(9'h141); bq.push_back(8); exp_done++;
    wr(32'h8001_0241);
    snap(1'b0, 15);
    // clear display takes the long wait
    cq.push_back(9'h001); bq.push_back(14); exp_done++;
    wr(32'h8000_0001);
    snap(1'b0, 22);
    // three back-to-back toggles: one active, one buffered, one dropped
    cq.push_back(9'h141); cq.push_back(9'h142); bq.push_back(16); exp_done += 2;
    wr(32'h8001_0241);
    wr(32'h8000_0242);
    wr(32'h8001_0243);
    snap(1'b1, 28);
    // same toggle bit, new data: nothing issued
    wr(32'h8001_0055);
    snap(1'b1, 15);
    // reset in the middle of the EN pulse
    cq.push_back(9'h133);
    wr(32'h8000_0233);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.lcd_en_o) break;
    end
    #2 rst_ni = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    cq.push_back(9'h148); bq.push_back(8); exp_done++;
    wr(32'h8001_0248);
    snap(1'b0, 15);
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lcd_cmd_driver.md
Name: lcd_cmd_driver

Overview:
- Consumes the `io_lcd` memory-mapped output register driven by the LSU.
- Converts each software-issued command into an HD44780-style character-LCD write cycle: RS/data setup, EN pulse, hold, then a command execution wait.
- Provides a one-entry command buffer, a busy/done status pair and a sticky overflow flag.
- Sits between the LSU `io_lcd` port and the board LCD pins.

Parameters:
- SETUP_CYC, 2, clocks RS/DATA are stable before EN rises (min 1).
- PULSE_CYC, 12, clocks EN is held high (min 1).
- HOLD_CYC, 2, clocks RS/DATA are held after EN falls (min 1).
- EXEC_CYC, 2000, post-write wait for normal commands and data (min 1).
- LONG_CYC, 82000, post-write wait for clear (0x01) and home (0x02/0x03) when RS=0 (min 1).

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- io_lcd  in  32  LSU register; [31]=ON, [16]=command toggle, [9]=RS, [7:0]=DATA; other bits ignored
- lcd_data_o  out  8  LCD data bus
- lcd_rs_o  out  1  register select
- lcd_rw_o  out  1  read/write; always 0 (write-only)
- lcd_en_o  out  1  enable strobe
- lcd_on_o  out  1  LCD power/backlight
- lcd_busy_o  out  1  transfer in progress
- lcd_done_o  out  1  one-cycle pulse per completed command
- lcd_ovf_o  out  1  sticky; a command was dropped

Behaviour:
- Reset is asynchronous and active-low; clk_i is the only clock. While rst_ni=0, every output is 0, the toggle shadow is 0, the buffer is empty and the FSM is IDLE. An assertion mid-transfer drops EN immediately and discards both the active and the buffered command.
- lcd_on_o is io_lcd[31] registered, so it has 1 cycle latency and is independent of the FSM.
- Command detect: tog_q <= io_lcd[16] every cycle. A new command is the cycle where io_lcd[16] != tog_q. {RS, DATA} is captured on that same edge.
- Software therefore issues a command by writing new RS/DATA with bit 16 inverted. Rewriting the same value issues nothing.
- FSM states: IDLE, SETUP, PULSE, HOLD, EXEC.
  - IDLE: when a command is detected, load it into the active registers (lcd_rs_o, lcd_data_o) and go to SETUP on the next edge.
  - SETUP: EN=0 for SETUP_CYC cycles, then PULSE.
  - PULSE: EN=1 for PULSE_CYC cycles, then HOLD.
  - HOLD: EN=0 for HOLD_CYC cycles; RS/DATA unchanged; then EXEC.
  - EXEC: wait LONG_CYC if RS=0 and DATA is in {0x01, 0x02, 0x03}, otherwise wait EXEC_CYC.
  - At the end of EXEC: pulse lcd_done_o for 1 cycle. If the buffer is full, pop it into the active registers and go to SETUP (busy stays 1); otherwise go to IDLE.
- lcd_busy_o = (state != IDLE). With 1-cycle detection latency, busy covers exactly SETUP_CYC+PULSE_CYC+HOLD_CYC+wait cycles per command.
- Buffer:
  - A command detected while busy and with the buffer empty is stored in the buffer.
  - A command detected while busy and with the buffer full is dropped and sets lcd_ovf_o.
  - A detect coinciding with the EXEC-end pop lands in the freed slot and is not dropped.
  - lcd_ovf_o is cleared only by reset.
- Counters use a single down-counter sized by $clog2 of the largest parameter. Each phase loads (N-1) and advances on zero. There is no wrap-around.
- lcd_rw_o is tied to 0.

Optional Feature:
- Macro: LCD_INIT_EN.
- Defined: after reset release the FSM first auto-issues 0x38, 0x0C, 0x01, 0x06, all with RS=0.
  - Each uses the normal timing; 0x01 uses LONG_CYC.
  - lcd_busy_o is 1 throughout the sequence, and no lcd_done_o pulses are emitted for it.
  - Toggles seen during init go through the normal buffer/overflow rules.
- Undefined: the FSM starts in IDLE directly after reset.

Test Plan (bench params SETUP=1, PULSE=2, HOLD=1, EXEC=4, LONG=10; LCD_INIT_EN undefined unless stated):
- Single write: io_lcd 0x0 -> 0x80010241. Required response:
  - lcd_on_o=1 next cycle; data=0x41, rs=1.
  - busy high 8 cycles; en high exactly cycles 2-3 of busy.
  - one done pulse; busy then returns to 0.
- Long command: io_lcd with [16] toggled, RS=0, DATA=0x01 -> busy high 14 cycles, en high 2 cycles, one done pulse.
- Buffering and overflow:
  - Three toggles (0x41, 0x42, 0x43) on consecutive writes during busy.
  - Required: 0x41 and 0x42 are emitted back-to-back with busy continuously high, 0x43 is dropped, lcd_ovf_o=1, and exactly two done pulses.
- No-toggle rewrite: rewrite io_lcd with the same bit 16 and new DATA=0x55 -> no EN pulse, busy stays 0.
- Mid-transfer reset: rst_ni=0 during PULSE.
  - Required: en, busy, data, rs and ovf all 0 immediately, without waiting for a clock edge.
  - After release, a fresh toggle completes a normal 8-cycle transfer.
- With LCD_INIT_EN defined: release reset -> EN pulses carry 0x38, 0x0C, 0x01, 0x06 in order; busy high for 3×8+14=38 cycles; no done pulses.
